input_debounce_latch: RTL

INPUT_DEBOUNCE_LATCH -- requirements
Module: input_debounce_latch

---
 rtl/input_debounce_latch_pkg.sv | 18 +
 rtl/debounce_bit.sv | 65 ++++++
 rtl/input_debounce_latch.sv | 73 +++++++
 3 files changed

// File: rtl/input_debounce_latch_pkg.sv
// rtl/input_debounce_latch_pkg.sv - shared constants for the input debounce/latch block
// Contents:
//    SYNC_STAGES          depth of the per-bit input synchronizer
//    DEBOUNCE_CYCLES_DEF  default number of stable samples to accept a new level
//    WIDTH_DEF            default channel count
//    cnt_width()          width of a counter that must reach n-1
package input_debounce_latch_pkg;

   localparam int SYNC_STAGES         = 2;
   localparam int DEBOUNCE_CYCLES_DEF = 16;
   localparam int WIDTH_DEF           = 8;

   // Smallest width holding n-1; never below one bit so n=2 still gets a flop.
   function automatic int cnt_width(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

endpackage

// File: rtl/debounce_bit.sv
// rtl/debounce_bit.sv - one channel: synchronizer, debounce counter, stable level
// Ports:
//    clk, rst_n   clock, synchronous active-low reset
//    ena          counter/stable advance enable (synchronizer always runs)
//    raw_in       asynchronous input bit
//    stable       debounced level (registered)
//    rise         high in the cycle whose edge will take stable from 0 to 1
module debounce_bit
   import input_debounce_latch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic ena,
   input  logic raw_in,
   output logic stable,
   output logic rise
);

   localparam int             CW      = cnt_width(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0]  CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync_q, sync_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic                   stable_q, stable_d;
   logic                   sync_lvl;

   assign sync_lvl = sync_q[SYNC_STAGES-1];

   always_comb begin
      sync_d   = {sync_q[SYNC_STAGES-2:0], raw_in};
      cnt_d    = cnt_q;
      stable_d = stable_q;
      rise     = 1'b0;
      if (ena) begin
         if (sync_lvl == stable_q) begin
            // Any agreement, even for one cycle, throws away the partial count.
            cnt_d = '0;
         end else if (cnt_q == CNT_MAX) begin
            // Mismatch seen DEBOUNCE_CYCLES times in a row: accept the new level.
            stable_d = sync_lvl;
            cnt_d    = '0;
            rise     = sync_lvl;
         end else begin
            cnt_d = cnt_q + CW'(1);
         end
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync_q   <= '0;
         cnt_q    <= '0;
         stable_q <= 1'b0;
      end else begin
         sync_q   <= sync_d;
         cnt_q    <= cnt_d;
         stable_q <= stable_d;
      end
   end

   assign stable = stable_q;

endmodule

// File: rtl/input_debounce_latch.sv
// rtl/input_debounce_latch.sv - multi-channel switch debouncer with sticky press latches
// Ports:
//    clk, rst_n   clock, synchronous active-low reset
//    ena          advance debounce counters, stable levels and latches
//    raw_in       asynchronous switch inputs, WIDTH bits
//    latch_mode   0: data_out = debounced levels, 1: data_out = sticky latches
//    clear        synchronous clear of all sticky latches (ignores ena)
//    data_out     registered output word
//    press        one-cycle pulse after any debounced bit rises
module input_debounce_latch
   import input_debounce_latch_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
   parameter int WIDTH           = WIDTH_DEF
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ena,
   input  logic [WIDTH-1:0] raw_in,
   input  logic             latch_mode,
   input  logic             clear,
   output logic [WIDTH-1:0] data_out,
   output logic             press
);

   logic [WIDTH-1:0] stable;
   logic [WIDTH-1:0] rise;

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_bit (
         .clk    (clk),
         .rst_n  (rst_n),
         .ena    (ena),
         .raw_in (raw_in[i]),
         .stable (stable[i]),
         .rise   (rise[i])
      );
   end

   logic [WIDTH-1:0] latched_q, latched_d;
   logic [WIDTH-1:0] stable_prev_q, stable_prev_d;
   logic [WIDTH-1:0] data_out_q, data_out_d;
   logic             press_q, press_d;

   always_comb begin
      // OR-ing rise after the clear lets a same-edge rising bit survive the clear.
      latched_d     = (clear ? '0 : latched_q) | rise;
      stable_prev_d = stable;
      // Edge detect on the registered level so press lines up with data_out.
      press_d       = |(stable & ~stable_prev_q);
      data_out_d    = latch_mode ? latched_q : stable;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         latched_q     <= '0;
         stable_prev_q <= '0;
         data_out_q    <= '0;
         press_q       <= 1'b0;
      end else begin
         latched_q     <= latched_d;
         stable_prev_q <= stable_prev_d;
         data_out_q    <= data_out_d;
         press_q       <= press_d;
      end
   end

   assign data_out = data_out_q;
   assign press    = press_q;

endmodule
